// File: rtl/m_007_scan_pkg.sv
// rtl/m_007_scan_pkg.sv - shared types, constants and anode helper for the digit scanner
package m_007_scan_pkg;

    localparam int unsigned MAX_DIGITS = 8;
    localparam int unsigned MAX_IDX_W  = $clog2(MAX_DIGITS);

    typedef logic [1:0] scan_state_t;

    localparam scan_state_t ST_IDLE  = 2'd0;
    localparam scan_state_t ST_BLANK = 2'd1;
    localparam scan_state_t ST_SHOW  = 2'd2;

    // One-hot active-low anode pattern: only the selected digit is driven low.
    function automatic logic [MAX_DIGITS-1:0] anode_pattern(input logic [MAX_IDX_W-1:0] idx);
        logic [MAX_DIGITS-1:0] pat;
        pat      = '1;
        pat[idx] = 1'b0;
        return pat;
    endfunction

endpackage

// File: rtl/m_007_prescaler.sv
// rtl/m_007_prescaler.sv - modulo-N slot counter with terminal-count and blank-end match
module m_007_prescaler #(
    parameter int MOD   = 50000,
    parameter int MATCH = 63,
    parameter int CNT_W = $clog2(MOD)
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    output logic tc_o,
    output logic match_o
);

    localparam logic [CNT_W-1:0] LAST    = CNT_W'(MOD - 1);
    localparam logic [CNT_W-1:0] MATCH_V = CNT_W'((MATCH < 0) ? 0 : MATCH);
    localparam bit               HAS_MATCH = (MATCH >= 0);

    logic [CNT_W-1:0] count;

    // Free-running slot position; cleared while the scanner is idle or disabled.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count <= '0;
        end else if (clear_i || (count == LAST)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tc_o    = (count == LAST);
    assign match_o = HAS_MATCH && (count == MATCH_V);

endmodule

// File: rtl/m_007_digit_scanner.sv
// rtl/m_007_digit_scanner.sv - 7-segment scan controller; optional LEADING_ZERO_BLANK_EN
module m_007_digit_scanner
    import m_007_scan_pkg::*;
#(
    parameter  int NUM_DIGITS   = 4,
    parameter  int REFRESH_DIV  = 50000,
    parameter  int BLANK_CYCLES = 64,
    localparam int IDX_W        = $clog2(NUM_DIGITS)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    en_i,
    input  logic                    load_i,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    output logic [3:0]              bcd_o,
    output logic                    dp_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic [IDX_W-1:0]        digit_idx_o,
    output logic                    frame_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    scan_state_t              state, state_n;
    logic [IDX_W-1:0]         idx, idx_n;
    logic [4*NUM_DIGITS-1:0]  sh_dig, sh_dig_n, stg_dig;
    logic [NUM_DIGITS-1:0]    sh_dp, sh_dp_n, stg_dp;
    logic [NUM_DIGITS-1:0]    an_n;
    logic                     pending, pending_n;
    logic                     wrap, commit;
    logic                     p_tc, p_match, p_clear;

    assign p_clear = !en_i || (state == ST_IDLE);

    m_007_prescaler #(
        .MOD   (REFRESH_DIV),
        .MATCH (BLANK_CYCLES - 1)
    ) u_prescaler (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (p_clear),
        .tc_o    (p_tc),
        .match_o (p_match)
    );

    // Scan sequencing: idle/blank/show with digit advance at the slot end.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        wrap    = 1'b0;
        if (!en_i) begin
            state_n = ST_IDLE;
            idx_n   = '0;
        end else begin
            case (state)
                ST_IDLE:  state_n = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
                ST_BLANK: if (p_match) state_n = ST_SHOW;
                ST_SHOW: begin
                    if (p_tc) begin
                        wrap    = (idx == LAST_IDX);
                        idx_n   = wrap ? '0 : idx + 1'b1;
                        state_n = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    idx_n   = '0;
                end
            endcase
        end
    end

    // Tear-free shadow: new digits land only while idle or on the frame wrap.
    always_comb begin
        commit    = (state == ST_IDLE) || wrap;
        sh_dig_n  = sh_dig;
        sh_dp_n   = sh_dp;
        pending_n = pending;
        if (commit) begin
            if (load_i) begin
                sh_dig_n = digits_i;
                sh_dp_n  = dp_i;
            end else if (pending) begin
                sh_dig_n = stg_dig;
                sh_dp_n  = stg_dp;
            end
            pending_n = 1'b0;
        end else if (load_i) begin
            pending_n = 1'b1;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lz_blank;
    logic                  upper_zero;

    // Suppress a digit above 0 when it and every higher digit are zero and no dp is requested.
    always_comb begin
        lz_blank   = '0;
        upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            upper_zero  = upper_zero && (sh_dig_n[4*i +: 4] == 4'd0);
            lz_blank[i] = upper_zero && !sh_dp_n[i];
        end
    end
`endif

    // Anode pattern for the upcoming cycle: only the active digit low, and only in SHOW.
    always_comb begin
        an_n = '1;
        if (state_n == ST_SHOW) begin
            an_n = NUM_DIGITS'(anode_pattern(MAX_IDX_W'(idx_n)));
        end
`ifdef LEADING_ZERO_BLANK_EN
        an_n = an_n | lz_blank;
`endif
    end

    // State, shadow and registered outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state   <= ST_IDLE;
            idx     <= '0;
            sh_dig  <= '0;
            sh_dp   <= '0;
            stg_dig <= '0;
            stg_dp  <= '0;
            pending <= 1'b0;
            an_o    <= '1;
            bcd_o   <= 4'd0;
            dp_o    <= 1'b0;
            frame_o <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            sh_dig  <= sh_dig_n;
            sh_dp   <= sh_dp_n;
            pending <= pending_n;
            if (load_i) begin
                stg_dig <= digits_i;
                stg_dp  <= dp_i;
            end
            an_o    <= an_n;
            bcd_o   <= sh_dig_n[{idx_n, 2'b00} +: 4];
            dp_o    <= sh_dp_n[idx_n];
            frame_o <= wrap;
        end
    end

    assign digit_idx_o = idx;

endmodule

// File: tb/tb_m_007_digit_scanner.sv
// tb/tb_m_007_digit_scanner.sv - randomized model-checked bench for the digit scanner
module tb_m_007_digit_scanner;

    localparam int NDIG  = 4;
    localparam int RDIV  = 4;
    localparam int FRAME = NDIG * RDIV;

    logic        clk, rst, en_i, load_i;
    logic [15:0] digits_i;
    logic [3:0]  dp_i;
    logic [3:0]  bcd_a, bcd_b, an_a, an_b;
    logic        dp_a, dp_b, frame_a, frame_b;
    logic [1:0]  idx_a, idx_b;

    int vectors, miscompares;

    // Behavioural model: running flag, cycle position within the frame, shadow/staging.
    bit          m_run, m_pend, m_frame;
    int          m_t;
    logic [15:0] m_sh, m_stg;
    logic [3:0]  m_sdp, m_stgdp;

    m_007_digit_scanner #(.NUM_DIGITS(NDIG), .REFRESH_DIV(RDIV), .BLANK_CYCLES(1)) u_dut (
        .clk_i(clk), .reset_i(rst), .en_i(en_i), .load_i(load_i), .digits_i(digits_i),
        .dp_i(dp_i), .bcd_o(bcd_a), .dp_o(dp_a), .an_o(an_a), .digit_idx_o(idx_a), .frame_o(frame_a));

    m_007_digit_scanner #(.NUM_DIGITS(NDIG), .REFRESH_DIV(RDIV), .BLANK_CYCLES(0)) u_dut_nb (
        .clk_i(clk), .reset_i(rst), .en_i(en_i), .load_i(load_i), .digits_i(digits_i),
        .dp_i(dp_i), .bcd_o(bcd_b), .dp_o(dp_b), .an_o(an_b), .digit_idx_o(idx_b), .frame_o(frame_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_an(input int blank);
        int         idx, ph;
        logic [3:0] a;
        bit         z;
        idx = (m_t / RDIV) % NDIG;
        ph  = m_t % RDIV;
        a   = 4'hF;
        z   = 1'b1;
        if (m_run && ph >= blank) begin
            a[idx] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            for (int i = idx; i < NDIG; i++) if (m_sh[4*i +: 4] != 4'd0) z = 1'b0;
            if (idx > 0 && !m_sdp[idx] && z) a = 4'hF;
`endif
        end
        return a;
    endfunction

    task automatic model_reset();
        m_run = 0; m_pend = 0; m_frame = 0; m_t = 0;
        m_sh = '0; m_sdp = '0; m_stg = '0; m_stgdp = '0;
    endtask

    task automatic model_update(input logic en, input logic ld, input logic [15:0] d, input logic [3:0] p);
        bit wrap;
        wrap = m_run && en && (m_t == FRAME - 1);
        if (!m_run || wrap) begin
            if (ld) begin
                m_sh = d; m_sdp = p;
            end else if (m_pend) begin
                m_sh = m_stg; m_sdp = m_stgdp;
            end
            m_pend = 0;
        end else if (ld) begin
            m_stg = d; m_stgdp = p; m_pend = 1;
        end
        m_frame = wrap;
        if (!en) begin
            m_run = 0; m_t = 0;
        end else if (!m_run) begin
            m_run = 1; m_t = 0;
        end else begin
            m_t = (m_t + 1) % FRAME;
        end
    endtask

    task automatic compare_all();
        int ei;
        ei = (m_t / RDIV) % NDIG;
        chk("bcd_a",   bcd_a,   m_sh[4*ei +: 4]);
        chk("dp_a",    dp_a,    m_sdp[ei]);
        chk("an_a",    an_a,    exp_an(1));
        chk("idx_a",   idx_a,   ei);
        chk("frame_a", frame_a, m_frame);
        chk("bcd_b",   bcd_b,   m_sh[4*ei +: 4]);
        chk("dp_b",    dp_b,    m_sdp[ei]);
        chk("an_b",    an_b,    exp_an(0));
        chk("idx_b",   idx_b,   ei);
        chk("frame_b", frame_b, m_frame);
    endtask

    task automatic step(input logic en, input logic ld, input logic [15:0] d, input logic [3:0] p);
        en_i = en; load_i = ld; digits_i = d; dp_i = p;
        model_update(en, ld, d, p);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'($urandom), 4'($urandom));
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1'b1; en_i = 1'b0; load_i = 1'b0; digits_i = '0; dp_i = '0;
        model_reset();
        #3;
        chk("rst_an",    an_a,    4'hF);
        chk("rst_bcd",   bcd_a,   4'h0);
        chk("rst_dp",    dp_a,    1'b0);
        chk("rst_idx",   idx_a,   2'd0);
        chk("rst_frame", frame_a, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        step(1'b1, 1'b1, 16'h4321, 4'h0);                    // t=0 blank digit 0
        chk("first_bcd", bcd_a, 4'h1);
        chk("first_blank", an_a, 4'hF);
        chk("nb_no_blank", an_b, 4'hE);
        step(1'b1, 1'b0, 16'h0, 4'h0);                       // t=1
        chk("show0", an_a, 4'hE);
        run(3);                                              // t=4
        chk("slot1_bcd", bcd_a, 4'h2);
        chk("slot1_blank", an_a, 4'hF);
        step(1'b1, 1'b0, 16'h0, 4'h0);                       // t=5
        chk("show1", an_a, 4'hD);
        step(1'b1, 1'b1, 16'h9876, 4'h0);                    // t=6, load pending
        chk("hold_bcd", bcd_a, 4'h2);
        run(3);                                              // t=9
        chk("old_digit2", bcd_a, 4'h3);
        chk("show2", an_a, 4'hB);
        run(6);                                              // t=15
        chk("old_digit3", bcd_a, 4'h4);
        chk("show3", an_a, 4'h7);
        chk("no_frame_yet", frame_a, 1'b0);
        step(1'b1, 1'b0, 16'h0, 4'h0);                       // t=0, new frame
        chk("frame_pulse", frame_a, 1'b1);
        chk("new_digit0", bcd_a, 4'h6);
        step(1'b1, 1'b0, 16'h0, 4'h0);                       // t=1
        chk("frame_one_cycle", frame_a, 1'b0);
        run(14);                                             // t=15
        step(1'b1, 1'b1, 16'h5A0C, 4'h1);                    // load on the wrap edge
        chk("wrap_load_bcd", bcd_a, 4'hC);
        chk("wrap_load_dp", dp_a, 1'b1);
        run(9);                                              // t=9, SHOW digit 2
        chk("pre_drop", an_a, 4'hB);
        step(1'b0, 1'b0, 16'h0, 4'h0);
        chk("drop_an", an_a, 4'hF);
        chk("drop_idx", idx_a, 2'd0);
        step(1'b1, 1'b0, 16'h0, 4'h0);                       // restart at t=0
        chk("restart_an", an_a, 4'hF);
        chk("restart_bcd", bcd_a, 4'hC);
        step(1'b1, 1'b1, 16'h1111, 4'hF);                    // t=1, pending load
        step(1'b1, 1'b0, 16'h0, 4'h0);                       // t=2, SHOW
        #2 rst = 1'b1;
        #1;
        chk("arst_an",  an_a,  4'hF);
        chk("arst_bcd", bcd_a, 4'h0);
        chk("arst_idx", idx_a, 2'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0, 16'h0, 4'h0);
        chk("discard_bcd", bcd_a, 4'h0);
        step(1'b1, 1'b0, 16'h0, 4'h0);
        chk("discard_an", an_a, 4'hE);

        for (int n = 0; n < 1500; n++) begin
            step(($urandom_range(15) != 0), ($urandom_range(7) == 0),
                 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(3))),
                 4'($urandom_range(15)) & 4'($urandom_range(15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
